mux_sel_gen: RTL and testbench

- Upstream control stage for the registered 2:1 select unit. Generates that unit's `sel` stream, plus a qualifying `valid` and a Versat-style `done`.
- After a `run` pulse it waits a programmable delay, then repeats: `sel=0` for `len0` cycles, then `sel=1` for `len1` cycles. This repeats `iter` times, after which it idles with `done` high.
- Used to interleave two datapath streams through the downstream mux without CPU involvement per cycle.

---
 rtl/mux_sel_gen.sv | 167 ++++++++++++++++
 tb/tb_mux_sel_gen.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mux_sel_gen.sv
`default_nettype none
// ============================================================================
//  Module      : mux_sel_gen
//  Description : Select-stream generator for the registered 2:1 select unit.
//                After a run pulse it waits a programmable delay, then emits
//                iter repetitions of (len0 cycles sel=0, len1 cycles sel=1),
//                qualified by valid, and raises done when idle/finished.
//                Optional macro MUX_SEL_GEN_PAUSE_EN adds a pause input that
//                freezes the sequence (valid forced low) while asserted.
//  Revision    : 1.0 - initial release
// ============================================================================
module mux_sel_gen #(
    parameter int DELAY_W = 8,
    parameter int LEN_W   = 16,
    parameter int ITER_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
`ifdef MUX_SEL_GEN_PAUSE_EN
    input  logic               pause,
`endif
    input  logic [DELAY_W-1:0] delay,
    input  logic [LEN_W-1:0]   len0,
    input  logic [LEN_W-1:0]   len1,
    input  logic [ITER_W-1:0]  iter,
    output logic               sel,
    output logic               valid,
    output logic               done
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_DELAY  = 2'd1;
    localparam logic [1:0] c_PHASE0 = 2'd2;
    localparam logic [1:0] c_PHASE1 = 2'd3;

    // Latched configuration, captured only at the run edge.
    logic [DELAY_W-1:0] r_delay_unused_guard;
    logic [LEN_W-1:0]   r_len0;
    logic [LEN_W-1:0]   r_len1;
    logic [ITER_W-1:0]  r_iter;

    // Sequencer state and counters.
    logic [1:0]         r_state;
    logic [DELAY_W-1:0] r_dcnt;    // remaining delay cycles
    logic [LEN_W-1:0]   r_pcnt;    // index of current cycle within phase
    logic [ITER_W-1:0]  r_icnt;    // completed iterations

    // Advance (one unpaused step) results.
    logic [1:0]         w_adv_state;
    logic [DELAY_W-1:0] w_adv_dcnt;
    logic [LEN_W-1:0]   w_adv_pcnt;
    logic [ITER_W-1:0]  w_adv_icnt;

    logic [LEN_W-1:0]   w_pcnt_inc;
    logic [ITER_W-1:0]  w_icnt_inc;
    logic               w_iter_last;
    logic [1:0]         w_first_phase;
    logic               w_run_degen;
    logic               w_hold;

`ifdef MUX_SEL_GEN_PAUSE_EN
    // Pause only matters while a sequence is in flight; IDLE ignores it.
    assign w_hold = pause && (r_state != c_IDLE);
`else
    assign w_hold = 1'b0;
`endif

    // A config with no iterations or two empty phases produces nothing.
    assign w_run_degen   = (iter == '0) || ((len0 == '0) && (len1 == '0));

    assign w_pcnt_inc    = r_pcnt + LEN_W'(1);
    assign w_icnt_inc    = r_icnt + ITER_W'(1);
    assign w_iter_last   = (w_icnt_inc == r_iter);
    // An empty phase 0 is skipped without spending a cycle.
    assign w_first_phase = (r_len0 != '0) ? c_PHASE0 : c_PHASE1;

    // Compute the next state/counters for a normal (not restarted, not paused) step.
    always_comb begin
        w_adv_state = r_state;
        w_adv_dcnt  = r_dcnt;
        w_adv_pcnt  = r_pcnt;
        w_adv_icnt  = r_icnt;
        case (r_state)
            c_DELAY: begin
                if (r_dcnt == '0) begin
                    w_adv_state = w_first_phase;
                end else begin
                    w_adv_dcnt = r_dcnt - DELAY_W'(1);
                end
            end
            c_PHASE0: begin
                if (w_pcnt_inc == r_len0) begin
                    w_adv_pcnt = '0;
                    if (r_len1 != '0) begin
                        w_adv_state = c_PHASE1;
                    end else begin
                        // No phase 1: the iteration ends with phase 0.
                        w_adv_icnt  = w_icnt_inc;
                        w_adv_state = w_iter_last ? c_IDLE : c_PHASE0;
                    end
                end else begin
                    w_adv_pcnt = w_pcnt_inc;
                end
            end
            c_PHASE1: begin
                if (w_pcnt_inc == r_len1) begin
                    w_adv_pcnt  = '0;
                    w_adv_icnt  = w_icnt_inc;
                    w_adv_state = w_iter_last ? c_IDLE : w_first_phase;
                end else begin
                    w_adv_pcnt = w_pcnt_inc;
                end
            end
            default: begin
                w_adv_state = c_IDLE;
            end
        endcase
    end

    // Sequencer register: restart on run, freeze on pause, else advance; outputs follow next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_dcnt  <= '0;
            r_pcnt  <= '0;
            r_icnt  <= '0;
            r_len0  <= '0;
            r_len1  <= '0;
            r_iter  <= '0;
            r_delay_unused_guard <= '0;
            sel     <= 1'b0;
            valid   <= 1'b0;
            done    <= 1'b1;
        end else if (run) begin
            r_len0  <= len0;
            r_len1  <= len1;
            r_iter  <= iter;
            r_delay_unused_guard <= delay;
            r_dcnt  <= delay;
            r_pcnt  <= '0;
            r_icnt  <= '0;
            sel     <= 1'b0;
            valid   <= 1'b0;
            if (w_run_degen) begin
                r_state <= c_IDLE;
                done    <= 1'b1;
            end else begin
                r_state <= c_DELAY;
                done    <= 1'b0;
            end
        end else if (w_hold) begin
            // Everything frozen; sel and done keep their values.
            valid   <= 1'b0;
        end else begin
            r_state <= w_adv_state;
            r_dcnt  <= w_adv_dcnt;
            r_pcnt  <= w_adv_pcnt;
            r_icnt  <= w_adv_icnt;
            sel     <= (w_adv_state == c_PHASE1);
            valid   <= (w_adv_state == c_PHASE0) || (w_adv_state == c_PHASE1);
            done    <= (w_adv_state == c_IDLE);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mux_sel_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mux_sel_gen
//  Description : Self-checking bench for mux_sel_gen: directed vector table
//                for the main stream behaviour plus hand-written sequences
//                for reset, restart and (when enabled) pause.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_sel_gen;

    logic        clk    = 1'b0;
    logic        clk_en = 1'b0;
    logic        rst    = 1'b0;
    logic        run    = 1'b0;
    logic [7:0]  delay  = '0;
    logic [15:0] len0   = '0;
    logic [15:0] len1   = '0;
    logic [15:0] iter   = '0;
`ifdef MUX_SEL_GEN_PAUSE_EN
    logic        pause  = 1'b0;
`endif
    logic        sel;
    logic        valid;
    logic        done;

    int n_cmp = 0;
    int n_bad = 0;

    mux_sel_gen #(
        .DELAY_W (8),
        .LEN_W   (16),
        .ITER_W  (16)
    ) u_dut (
        .clk   (clk),
        .rst   (rst),
        .run   (run),
`ifdef MUX_SEL_GEN_PAUSE_EN
        .pause (pause),
`endif
        .delay (delay),
        .len0  (len0),
        .len1  (len1),
        .iter  (iter),
        .sel   (sel),
        .valid (valid),
        .done  (done)
    );

    // Free-running clock that can be stopped to prove reset is asynchronous.
    always #5 if (clk_en) clk = ~clk;

    typedef struct {
        int          d;
        int          l0;
        int          l1;
        int          it;
        int          tot;   // expected active cycles
        logic [31:0] pat;   // bit a = expected sel of active cycle a
    } vec_t;

    localparam int NV = 8;
    vec_t vecs [NV];

    // Compare {sel,valid,done} against an expected triple.
    task automatic chk(input string name, input logic [2:0] exp);
        logic [2:0] act;
        act = {sel, valid, done};
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: {sel,valid,done} got %b required %b at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step_chk(input string name, input logic [2:0] exp);
        tick();
        chk(name, exp);
    endtask

    // Present config with run high for exactly one edge; returns just after that edge.
    task automatic start(input int d, input int l0, input int l1, input int it);
        delay = 8'(d);
        len0  = 16'(l0);
        len1  = 16'(l1);
        iter  = 16'(it);
        run   = 1'b1;
        tick();
        run   = 1'b0;
    endtask

    initial begin
        // d, l0, l1, it, total, sel pattern
        vecs[0] = '{2, 3, 2, 2, 10, 32'h0000_0318};
        vecs[1] = '{0, 0, 4, 1,  4, 32'h0000_000F};
        vecs[2] = '{0, 2, 0, 3,  6, 32'h0000_0000};
        vecs[3] = '{1, 1, 1, 3,  6, 32'h0000_002A};
        vecs[4] = '{3, 1, 2, 1,  3, 32'h0000_0006};
        vecs[5] = '{1, 3, 3, 0,  0, 32'h0000_0000};
        vecs[6] = '{0, 0, 0, 5,  0, 32'h0000_0000};
        vecs[7] = '{0, 1, 0, 2,  2, 32'h0000_0000};

        // Reset with the clock stopped must take effect immediately.
        #1 rst = 1'b1;
        #1 chk("reset_async", 3'b001);
        #2 rst = 1'b0;
        #1 clk_en = 1'b1;
        for (int i = 0; i < 10; i++) step_chk($sformatf("idle_%0d", i), 3'b001);

        // Table-driven streams.
        for (int v = 0; v < NV; v++) begin
            start(vecs[v].d, vecs[v].l0, vecs[v].l1, vecs[v].it);
            for (int k = 0; k <= vecs[v].d + vecs[v].tot + 2; k++) begin
                logic [2:0] exp;
                int a;
                if (k > 0) tick();
                a = k - (vecs[v].d + 1);
                if (vecs[v].tot == 0)        exp = 3'b001;
                else if (a < 0)              exp = 3'b000;
                else if (a < vecs[v].tot)    exp = {vecs[v].pat[a], 1'b1, 1'b0};
                else                         exp = 3'b001;
                chk($sformatf("vec%0d_k%0d", v, k), exp);
            end
        end

        // Restart on the 4th active cycle with a new short config.
        start(0, 5, 5, 3);
        chk("rs_delay", 3'b000);
        for (int i = 1; i <= 4; i++) step_chk($sformatf("rs_act%0d", i), 3'b010);
        delay = 8'd1; len0 = 16'd1; len1 = 16'd1; iter = 16'd1;
        run = 1'b1;
        tick();
        run = 1'b0;
        chk("rs_new_d0", 3'b000);
        step_chk("rs_new_d1", 3'b000);
        step_chk("rs_new_p0", 3'b010);
        step_chk("rs_new_p1", 3'b110);
        step_chk("rs_done0", 3'b001);
        step_chk("rs_done1", 3'b001);

        // run coincident with the last active cycle: restart wins, done stays low.
        start(0, 1, 1, 1);
        chk("lr_delay", 3'b000);
        step_chk("lr_p0", 3'b010);
        step_chk("lr_p1_last", 3'b110);
        delay = 8'd0; len0 = 16'd2; len1 = 16'd0; iter = 16'd1;
        run = 1'b1;
        tick();
        run = 1'b0;
        chk("lr_restart", 3'b000);
        step_chk("lr_new0", 3'b010);
        step_chk("lr_new1", 3'b010);
        step_chk("lr_done", 3'b001);

        // Asynchronous reset in the middle of an active phase with the clock stopped.
        start(0, 5, 5, 3);
        step_chk("mr_act1", 3'b010);
        step_chk("mr_act2", 3'b010);
        clk_en = 1'b0;
        #1 rst = 1'b1;
        #1 chk("mr_reset", 3'b001);
        #10 chk("mr_reset_hold", 3'b001);
        rst = 1'b0;
        #1 clk_en = 1'b1;
        for (int i = 0; i < 3; i++) step_chk($sformatf("mr_idle%0d", i), 3'b001);

`ifdef MUX_SEL_GEN_PAUSE_EN
        // Pause for three cycles starting during the 2nd active cycle.
        begin
            int n_act;
            n_act = 0;
            start(0, 4, 4, 1);
            chk("pz_delay", 3'b000);
            step_chk("pz_act1", 3'b010);
            step_chk("pz_act2", 3'b010);
            n_act = 2;
            pause = 1'b1;
            for (int i = 0; i < 3; i++) step_chk($sformatf("pz_hold%0d", i), 3'b000);
            pause = 1'b0;
            for (int i = 0; i < 6; i++) begin
                step_chk($sformatf("pz_res%0d", i), (i < 2) ? 3'b010 : 3'b110);
                if (valid) n_act++;
            end
            step_chk("pz_done", 3'b001);
            n_cmp++;
            if (n_act != 8) begin
                n_bad++;
                $display("FAIL pz_count: active cycles got %0d required 8", n_act);
            end
            // Pause is ignored while idle.
            pause = 1'b1;
            step_chk("pz_idle", 3'b001);
            pause = 1'b0;
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
